// File: rtl/hilo_if.sv
// HI/LO unit bus: EX-stage request and result inputs, forwarding and architectural outputs.
interface hilo_if;
  logic        ex_valid_i;
  logic [2:0]  ex_hilo_op_i;
  logic [31:0] ex_rs_data_i;
  logic [63:0] div_result_i;
  logic        div_stall_i;
  logic [63:0] mul_result_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] mf_data_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        mem_pending_o;

  modport master (
    output ex_valid_i, ex_hilo_op_i, ex_rs_data_i, div_result_i, div_stall_i,
           mul_result_i, stall_i, flush_i,
    input  mf_data_o, hi_o, lo_o, mem_pending_o
  );

  modport slave (
    input  ex_valid_i, ex_hilo_op_i, ex_rs_data_i, div_result_i, div_stall_i,
           mul_result_i, stall_i, flush_i,
    output mf_data_o, hi_o, lo_o, mem_pending_o
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file with a one-entry MEM write stage: EX captures, MEM commits (2-edge latency).
// stall_i freezes everything; flush_i kills the MEM entry and the EX op; MFHI/MFLO forward from MEM.
module hilo_unit (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);

  localparam logic [2:0] OP_MTHI = 3'd1;
  localparam logic [2:0] OP_MTLO = 3'd2;
  localparam logic [2:0] OP_DIVW = 3'd3;
  localparam logic [2:0] OP_MULW = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef struct packed {
    logic        vld;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] hi_dat;
    logic [31:0] lo_dat;
  } mem_t;

  mem_t        mem_q, mem_d, ex_entry;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        advance, capture;

  assign advance = !bus.stall_i && !bus.flush_i;

  always_comb begin
    ex_entry = '0;
    unique case (bus.ex_hilo_op_i)
      OP_MTHI: begin
        ex_entry.we_hi  = 1'b1;
        ex_entry.hi_dat = bus.ex_rs_data_i;
      end
      OP_MTLO: begin
        ex_entry.we_lo  = 1'b1;
        ex_entry.lo_dat = bus.ex_rs_data_i;
      end
      OP_DIVW: begin
        ex_entry.we_hi  = 1'b1;
        ex_entry.we_lo  = 1'b1;
        ex_entry.hi_dat = bus.div_result_i[63:32];
        ex_entry.lo_dat = bus.div_result_i[31:0];
      end
      OP_MULW: begin
        ex_entry.we_hi  = 1'b1;
        ex_entry.we_lo  = 1'b1;
        ex_entry.hi_dat = bus.mul_result_i[63:32];
        ex_entry.lo_dat = bus.mul_result_i[31:0];
      end
      default: ex_entry = '0;
    endcase
    ex_entry.vld = ex_entry.we_hi || ex_entry.we_lo;
  end

  // A busy divider keeps the EX op out of MEM until its result is final.
  assign capture = advance && bus.ex_valid_i && !bus.div_stall_i && ex_entry.vld;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    mem_d = mem_q;
    if (bus.flush_i) begin
      mem_d.vld = 1'b0;
    end else if (!bus.stall_i) begin
      if (mem_q.vld && mem_q.we_hi) hi_d = mem_q.hi_dat;
      if (mem_q.vld && mem_q.we_lo) lo_d = mem_q.lo_dat;
      mem_d = capture ? ex_entry : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      mem_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mem_q <= mem_d;
    end
  end

  always_comb begin
    bus.mf_data_o = '0;
    if (bus.ex_hilo_op_i == OP_MFHI)
      bus.mf_data_o = (mem_q.vld && mem_q.we_hi) ? mem_q.hi_dat : hi_q;
    else if (bus.ex_hilo_op_i == OP_MFLO)
      bus.mf_data_o = (mem_q.vld && mem_q.we_lo) ? mem_q.lo_dat : lo_q;
  end

  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
  assign bus.mem_pending_o = mem_q.vld;

endmodule
